// File: rtl/toggle_monitor_pkg.sv
// Shared helpers for the toggle-coverage monitor: width functions for the
// read select and the coverage count.
package toggle_monitor_pkg;

   function automatic int sel_w_f(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int cov_w_f(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/toggle_monitor_if.sv
// Control, sample and read-port bundle for toggle_monitor.
// No handshake: en qualifies din for one edge, rd_sel is read every edge.
interface toggle_monitor_if
   import toggle_monitor_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4,
   parameter int SEL_W = sel_w_f(WIDTH)
);
   localparam int COV_W = cov_w_f(WIDTH);

   logic             en;
   logic             clr;
   logic [WIDTH-1:0] din;
   logic [SEL_W-1:0] rd_sel;
   logic [CNT_W-1:0] rd_cnt;
   logic             rd_rise;
   logic             rd_fall;
   logic [COV_W-1:0] cov_cnt;
   logic             full_cov;

   modport master (
      output en, clr, din, rd_sel,
      input  rd_cnt, rd_rise, rd_fall, cov_cnt, full_cov
   );

   modport slave (
      input  en, clr, din, rd_sel,
      output rd_cnt, rd_rise, rd_fall, cov_cnt, full_cov
   );
endinterface

// File: rtl/toggle_bit_cell.sv
// One monitored bit: previous sample, sticky rise/fall flags and a
// saturating toggle counter.
module toggle_bit_cell #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample,
   input  logic             prev_valid,
   input  logic             clr,
   input  logic             din,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] cnt
);
   logic prev;
   logic toggled;

   assign toggled = prev_valid & (prev ^ din);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
         cnt  <= '0;
      end else if (clr) begin
         // prev is left alone: prev_valid drops, so the next sample re-primes it
         rise <= 1'b0;
         fall <= 1'b0;
         cnt  <= '0;
      end else if (sample) begin
         if (prev_valid) begin
            rise <= rise | (~prev & din);
            fall <= fall | (prev & ~din);
            if (toggled && (cnt != '1)) cnt <= cnt + CNT_W'(1);
         end
         prev <= din;
      end
   end
endmodule

// File: rtl/toggle_monitor.sv
// Per-bit toggle-coverage monitor: a bit cell per input, a shared first-sample
// flag, a registered read port and a combinational coverage popcount.
module toggle_monitor
   import toggle_monitor_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4,
   parameter int SEL_W = sel_w_f(WIDTH)
) (
   input logic              clk,
   input logic              rst_n,
   toggle_monitor_if.slave  bus
);
   localparam int COV_W = cov_w_f(WIDTH);
   localparam int PAD   = 2 ** SEL_W;

   typedef struct packed {
      logic             rise;
      logic             fall;
      logic [CNT_W-1:0] cnt;
   } rec_t;

   logic             prev_valid;
   rec_t             rec     [WIDTH];
   rec_t             rec_pad [PAD];
   logic [WIDTH-1:0] both;
   logic [COV_W-1:0] cov;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      toggle_bit_cell #(.CNT_W(CNT_W)) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .sample     (bus.en),
         .prev_valid (prev_valid),
         .clr        (bus.clr),
         .din        (bus.din[g]),
         .rise       (rec[g].rise),
         .fall       (rec[g].fall),
         .cnt        (rec[g].cnt)
      );
      assign both[g] = rec[g].rise & rec[g].fall;
   end

   // Unused select codes read as an all-zero record.
   for (genvar p = 0; p < PAD; p++) begin : g_pad
      if (p < WIDTH) begin : g_real
         assign rec_pad[p] = rec[p];
      end else begin : g_zero
         assign rec_pad[p] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else if (bus.clr) begin
         prev_valid <= 1'b0;
      end else if (bus.en) begin
         prev_valid <= 1'b1;
      end
   end

   // Read register samples pre-update state and is not blocked by clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_cnt  <= '0;
         bus.rd_rise <= 1'b0;
         bus.rd_fall <= 1'b0;
      end else begin
         bus.rd_cnt  <= rec_pad[bus.rd_sel].cnt;
         bus.rd_rise <= rec_pad[bus.rd_sel].rise;
         bus.rd_fall <= rec_pad[bus.rd_sel].fall;
      end
   end

   always_comb begin
      cov = '0;
      for (int i = 0; i < WIDTH; i++) cov = cov + COV_W'(both[i]);
   end

   assign bus.cov_cnt  = cov;
   assign bus.full_cov = (cov == COV_W'(WIDTH));
endmodule

// File: tb/tb_toggle_monitor.sv
// Randomised and directed bench for toggle_monitor (WIDTH=4, CNT_W=3) with a
// second WIDTH=5 instance for out-of-range read selects.
module tb_toggle_monitor;
   localparam int W    = 4;
   localparam int CW   = 3;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   toggle_monitor_if #(.WIDTH(W), .CNT_W(CW)) bus ();
   toggle_monitor_if #(.WIDTH(5), .CNT_W(CW)) bus2 ();

   toggle_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   toggle_monitor #(.WIDTH(5), .CNT_W(CW)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   // Reference model: per-bit history as plain integers and bit vectors.
   logic [W-1:0]  m_prev;
   logic [W-1:0]  m_rise;
   logic [W-1:0]  m_fall;
   int            m_cnt [W];
   bit            m_pv;
   logic [CW-1:0] m_rd_cnt;
   logic          m_rd_rise;
   logic          m_rd_fall;

   function automatic void model_reset();
      m_prev = '0; m_rise = '0; m_fall = '0; m_pv = 1'b0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_rd_cnt = '0; m_rd_rise = 1'b0; m_rd_fall = 1'b0;
   endfunction

   function automatic void model_step(logic e, logic c, logic [W-1:0] d, int s);
      if (s < W) begin
         m_rd_cnt = CW'(m_cnt[s]); m_rd_rise = m_rise[s]; m_rd_fall = m_fall[s];
      end else begin
         m_rd_cnt = '0; m_rd_rise = 1'b0; m_rd_fall = 1'b0;
      end
      if (c) begin
         m_rise = '0; m_fall = '0; m_pv = 1'b0;
         for (int i = 0; i < W; i++) m_cnt[i] = 0;
      end else if (e) begin
         if (m_pv) begin
            for (int i = 0; i < W; i++) begin
               if (d[i] != m_prev[i]) begin
                  if (d[i]) m_rise[i] = 1'b1;
                  else      m_fall[i] = 1'b1;
                  m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
               end
            end
         end
         m_prev = d;
         m_pv = 1'b1;
      end
   endfunction

   function automatic int model_cov();
      return $countones(m_rise & m_fall);
   endfunction

   task automatic cycle(input logic e, input logic c, input logic [W-1:0] d, input int s);
      bus.en = e; bus.clr = c; bus.din = d; bus.rd_sel = 2'(s);
      @(posedge clk);
      model_step(e, c, d, s);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus.rd_cnt, bus.rd_rise, bus.rd_fall} !== '0) begin
         fails++;
         $display("FAIL reset_rd: got cnt=%0d r=%b f=%b want 0", bus.rd_cnt, bus.rd_rise, bus.rd_fall);
      end
      checks++;
      if (bus.cov_cnt !== 3'd0 || bus.full_cov !== 1'b0) begin
         fails++;
         $display("FAIL reset_cov: got cov=%0d full=%b want 0/0", bus.cov_cnt, bus.full_cov);
      end
   endtask

   task automatic test_first_sample();
      cycle(1'b1, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b0101, 0);
      checks++;
      if (bus.cov_cnt !== 3'd0) begin
         fails++;
         $display("FAIL first_sample_cov: got %0d want 0", bus.cov_cnt);
      end
      for (int b = 0; b < W; b++) begin
         cycle(1'b0, 1'b0, 4'b0101, b);
         checks++;
         if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {b % 2 == 0, 1'b0, CW'(b % 2 == 0)}
             || {bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {m_rd_rise, m_rd_fall, m_rd_cnt}) begin
            fails++;
            $display("FAIL first_sample_bit%0d: got r=%b f=%b c=%0d want r=%b f=%b c=%0d",
                     b, bus.rd_rise, bus.rd_fall, bus.rd_cnt, m_rd_rise, m_rd_fall, m_rd_cnt);
         end
      end
   endtask

   task automatic test_saturate();
      cycle(1'b0, 1'b1, 4'b0000, 0);
      for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 4'(k % 2), 0);
      cycle(1'b0, 1'b0, 4'b0000, 0);
      checks++;
      if (bus.rd_cnt !== CW'(MAXC) || bus.rd_rise !== 1'b1 || bus.rd_fall !== 1'b1) begin
         fails++;
         $display("FAIL saturate: got c=%0d r=%b f=%b want c=%0d r=1 f=1", bus.rd_cnt, bus.rd_rise, bus.rd_fall, MAXC);
      end
      cycle(1'b1, 1'b0, 4'b0001, 0);
      cycle(1'b0, 1'b0, 4'b0001, 0);
      checks++;
      if (bus.rd_cnt !== CW'(MAXC)) begin
         fails++;
         $display("FAIL saturate_hold: got %0d want %0d", bus.rd_cnt, MAXC);
      end
   endtask

   task automatic test_full_cov();
      cycle(1'b0, 1'b1, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b1111, 0);
      checks++;
      if (bus.full_cov !== 1'b0) begin
         fails++;
         $display("FAIL full_cov_early: got %b want 0", bus.full_cov);
      end
      cycle(1'b1, 1'b0, 4'b0000, 0);
      checks++;
      if (bus.cov_cnt !== 3'd4 || bus.full_cov !== 1'b1) begin
         fails++;
         $display("FAIL full_cov: got cov=%0d full=%b want 4/1", bus.cov_cnt, bus.full_cov);
      end
   endtask

   task automatic test_disabled();
      cycle(1'b0, 1'b1, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b0000, 0);
      cycle(1'b0, 1'b0, 4'b1000, 0);
      cycle(1'b0, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b0000, 0);
      for (int b = 0; b < W; b++) begin
         cycle(1'b0, 1'b0, 4'b0110, b);
         checks++;
         if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== '0) begin
            fails++;
            $display("FAIL disabled_bit%0d: got r=%b f=%b c=%0d want 0", b, bus.rd_rise, bus.rd_fall, bus.rd_cnt);
         end
      end
   endtask

   task automatic test_clear();
      cycle(1'b1, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b0, 4'b0011, 0);
      cycle(1'b1, 1'b0, 4'b0000, 0);
      cycle(1'b1, 1'b1, 4'b1010, 0);
      checks++;
      if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {1'b1, 1'b1, CW'(2)} || bus.cov_cnt !== 3'd0) begin
         fails++;
         $display("FAIL clear_old_read: got r=%b f=%b c=%0d cov=%0d want r=1 f=1 c=2 cov=0",
                  bus.rd_rise, bus.rd_fall, bus.rd_cnt, bus.cov_cnt);
      end
      cycle(1'b0, 1'b0, 4'b0101, 0);
      checks++;
      if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== '0) begin
         fails++;
         $display("FAIL clear_zero_read: got r=%b f=%b c=%0d want 0", bus.rd_rise, bus.rd_fall, bus.rd_cnt);
      end
      cycle(1'b1, 1'b0, 4'b1111, 0);
      cycle(1'b1, 1'b0, 4'b1111, 0);
      for (int b = 0; b < W; b++) begin
         cycle(1'b0, 1'b0, 4'b0000, b);
         checks++;
         if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== '0) begin
            fails++;
            $display("FAIL clear_first_bit%0d: got r=%b f=%b c=%0d want 0", b, bus.rd_rise, bus.rd_fall, bus.rd_cnt);
         end
      end
   endtask

   task automatic test_random();
      logic e, c;
      logic [W-1:0] d;
      int s;
      for (int k = 0; k < 400; k++) begin
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 40) == 0);
         d = W'($urandom_range(0, 15));
         s = $urandom_range(0, W - 1);
         cycle(e, c, d, s);
         checks++;
         if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {m_rd_rise, m_rd_fall, m_rd_cnt}) begin
            fails++;
            $display("FAIL random_rd k=%0d: got r=%b f=%b c=%0d want r=%b f=%b c=%0d",
                     k, bus.rd_rise, bus.rd_fall, bus.rd_cnt, m_rd_rise, m_rd_fall, m_rd_cnt);
         end
         checks++;
         if (bus.cov_cnt !== 3'(model_cov()) || bus.full_cov !== (model_cov() == W)) begin
            fails++;
            $display("FAIL random_cov k=%0d: got cov=%0d full=%b want cov=%0d", k, bus.cov_cnt, bus.full_cov, model_cov());
         end
      end
   endtask

   task automatic test_out_of_range();
      bus.en = 1'b0; bus.clr = 1'b0;
      bus2.clr = 1'b0; bus2.en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus2.din = 5'(k[0] ? 5'b11111 : 5'b00000);
         bus2.rd_sel = 3'($urandom_range(0, 4));
         @(posedge clk); #1;
      end
      bus2.en = 1'b0;
      for (int s = 5; s < 8; s++) begin
         bus2.rd_sel = 3'(s);
         @(posedge clk); #1;
         checks++;
         if ({bus2.rd_rise, bus2.rd_fall, bus2.rd_cnt} !== '0) begin
            fails++;
            $display("FAIL out_of_range sel=%0d: got r=%b f=%b c=%0d want 0", s, bus2.rd_rise, bus2.rd_fall, bus2.rd_cnt);
         end
      end
      bus2.rd_sel = 3'd0;
      @(posedge clk); #1;
      checks++;
      if ({bus2.rd_rise, bus2.rd_fall} !== 2'b11 || bus2.full_cov !== 1'b1) begin
         fails++;
         $display("FAIL in_range_w5: got r=%b f=%b full=%b want 1/1/1", bus2.rd_rise, bus2.rd_fall, bus2.full_cov);
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 1'b0, 4'b0000, 1);
      cycle(1'b1, 1'b0, 4'b1111, 1);
      cycle(1'b1, 1'b0, 4'b0000, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.rd_cnt, bus.rd_rise, bus.rd_fall} !== '0 || bus.cov_cnt !== 3'd0 || bus.full_cov !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: got c=%0d r=%b f=%b cov=%0d full=%b want 0",
                  bus.rd_cnt, bus.rd_rise, bus.rd_fall, bus.cov_cnt, bus.full_cov);
      end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 4'b1111, 0);
      cycle(1'b1, 1'b0, 4'b0000, 0);
      for (int b = 0; b < W; b++) begin
         cycle(1'b0, 1'b0, 4'b0000, b);
         checks++;
         if ({bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {1'b0, 1'b1, CW'(1)}
             || {bus.rd_rise, bus.rd_fall, bus.rd_cnt} !== {m_rd_rise, m_rd_fall, m_rd_cnt}) begin
            fails++;
            $display("FAIL reset_release_bit%0d: got r=%b f=%b c=%0d want r=0 f=1 c=1",
                     b, bus.rd_rise, bus.rd_fall, bus.rd_cnt);
         end
      end
   endtask

   initial begin
      bus.en = 1'b0; bus.clr = 1'b0; bus.din = '0; bus.rd_sel = '0;
      bus2.en = 1'b0; bus2.clr = 1'b0; bus2.din = '0; bus2.rd_sel = '0;
      model_reset();
      #12;
      test_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      test_first_sample();
      test_saturate();
      test_full_cov();
      test_disabled();
      test_clear();
      test_random();
      test_out_of_range();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
